// File: rtl/mio_bus_arbiter.sv
// Two-master / one-slave bus arbiter with round-robin tie breaking,
// grant held until slave acknowledge, one-cycle ready pulse back to the
// owning master, and a watchdog that aborts transfers the slave ignores.
module mio_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg;
  logic        last_reg;      // 1 = master 1 was granted last time
  logic        owner_reg;     // current owner index
  logic [7:0]  wait_cnt_reg;
  logic [1:0]  ready_reg;
  logic [31:0] rdata_reg [0:1];
  logic        s_req_reg;
  logic        s_we_reg;
  logic [31:0] s_addr_reg;
  logic [31:0] s_wdata_reg;
  logic [1:0]  grant_reg;
  logic        timeout_err_reg;
  logic        pick_m1;

  // Winner select: lone requester wins, a tie goes to whoever was not last
  always_comb begin
    pick_m1 = m1_req && (!m0_req || !last_reg);
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_reg        <= 1'b1;
      owner_reg       <= 1'b0;
      wait_cnt_reg    <= 8'd0;
      ready_reg       <= 2'b00;
      rdata_reg[0]    <= 32'd0;
      rdata_reg[1]    <= 32'd0;
      s_req_reg       <= 1'b0;
      s_we_reg        <= 1'b0;
      s_addr_reg      <= 32'd0;
      s_wdata_reg     <= 32'd0;
      grant_reg       <= 2'b00;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner_reg    <= pick_m1;
            last_reg     <= pick_m1;
            s_we_reg     <= pick_m1 ? m1_we    : m0_we;
            s_addr_reg   <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata_reg  <= pick_m1 ? m1_wdata : m0_wdata;
            s_req_reg    <= 1'b1;
            grant_reg    <= pick_m1 ? 2'b10 : 2'b01;
            wait_cnt_reg <= 8'd0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          // An ack in the timeout cycle still counts as a normal completion
          if (s_ack) begin
            if (!s_we_reg) begin
              rdata_reg[owner_reg] <= s_rdata;
            end
            s_req_reg            <= 1'b0;
            ready_reg[owner_reg] <= 1'b1;
            state_reg            <= DONE;
          end else if (wait_cnt_reg == TIMEOUT_CNT) begin
            rdata_reg[owner_reg] <= 32'hFFFF_FFFF;
            s_req_reg            <= 1'b0;
            ready_reg[owner_reg] <= 1'b1;
            timeout_err_reg      <= 1'b1;
            state_reg            <= DONE;
          end
        end
        DONE: begin
          ready_reg <= 2'b00;
          grant_reg <= 2'b00;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign m0_rdata    = rdata_reg[0];
  assign m1_rdata    = rdata_reg[1];
  assign m0_ready    = ready_reg[0];
  assign m1_ready    = ready_reg[1];
  assign s_req       = s_req_reg;
  assign s_we        = s_we_reg;
  assign s_addr      = s_addr_reg;
  assign s_wdata     = s_wdata_reg;
  assign grant       = grant_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: each scenario task drives masters, pushes the
// expected completion (master, data, cycle) to a scoreboard queue and pops
// it when a ready pulse appears.
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m0_rdata;
  logic        m0_ready;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0, m1_rdata;
  logic        m1_ready;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = 32'd0;
  logic        s_ack = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          m;
    logic [31:0] d;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_rdata [0:1];

  // slave behaviour knobs
  logic slave_en   = 1'b1;
  int   slave_wait = 0;

  mio_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: acks slave_wait cycles after s_req rises, data = addr ^ A5A5A5A5
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s_req && slave_en) begin
        if (wcnt == slave_wait) begin
          s_ack   = 1'b1;
          s_rdata = s_addr ^ 32'hA5A5_A5A5;
        end else begin
          s_ack = 1'b0;
        end
        wcnt++;
      end else begin
        s_ack = 1'b0;
        wcnt  = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({s_req, s_we, s_addr, s_wdata, m0_rdata, m1_rdata, m0_ready, m1_ready, grant, timeout_err} !== 136'd0) begin
      fails++;
      $display("FAIL reset_outputs: got s_req=%b grant=%b s_addr=%h m0_rdata=%h m1_rdata=%h terr=%b, required all zero",
               s_req, grant, s_addr, m0_rdata, m1_rdata, timeout_err);
    end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_single_read();
    exp_t e;
    slave_en = 1'b1;
    slave_wait = 0;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    model_rdata[0] = 32'h0000_0010 ^ 32'hA5A5_A5A5;
    sb.push_back('{0, model_rdata[0], 2});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h10 || grant !== 2'b01) begin
          fails++;
          $display("FAIL single_read_c1: got s_req=%b s_addr=%h grant=%b, required 1 00000010 01", s_req, s_addr, grant);
        end
      end
      if (c == 2) begin
        tests++;
        if (grant !== 2'b01) begin
          fails++;
          $display("FAIL single_read_grant_c2: got %b, required 01", grant);
        end
      end
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || (m1_ready ? m1_rdata : m0_rdata) !== e.d || c !== e.cyc) begin
          fails++;
          $display("FAIL single_read_done: got m%0d data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                   m1_ready ? 1 : 0, m1_ready ? m1_rdata : m0_rdata, c, e.m, e.d, e.cyc);
        end
        $display("[TB] single_read: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL single_read_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    slave_en = 1'b1;
    slave_wait = 0;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    model_rdata[0] = 32'h100 ^ 32'hA5A5_A5A5;
    model_rdata[1] = 32'h200 ^ 32'hA5A5_A5A5;
    sb.push_back('{0, model_rdata[0], 2});
    sb.push_back('{1, model_rdata[1], 5});
    sb.push_back('{0, model_rdata[0], 8});
    sb.push_back('{1, model_rdata[1], 11});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3 || c == 4) begin
        tests++;
        if (grant !== (c == 3 ? 2'b00 : 2'b10)) begin
          fails++;
          $display("FAIL rr_grant_c%0d: got %b, required %b", c, grant, c == 3 ? 2'b00 : 2'b10);
        end
      end
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || (m1_ready ? m1_rdata : m0_rdata) !== e.d || c !== e.cyc) begin
          fails++;
          $display("FAIL rr_done: got m%0d data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                   m1_ready ? 1 : 0, m1_ready ? m1_rdata : m0_rdata, c, e.m, e.d, e.cyc);
        end
        $display("[TB] round_robin: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rr_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_write_wait();
    exp_t e;
    slave_en = 1'b1;
    slave_wait = 3;
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'hCAFE_F00D;
    sb.push_back('{1, model_rdata[1], 5});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        tests++;
        if (s_req !== 1'b1 || s_we !== 1'b1 || s_wdata !== 32'hCAFE_F00D || s_addr !== 32'h8000_0000 || grant !== 2'b10) begin
          fails++;
          $display("FAIL write_hold_c%0d: got s_req=%b s_we=%b s_addr=%h s_wdata=%h grant=%b, required 1 1 80000000 cafef00d 10",
                   c, s_req, s_we, s_addr, s_wdata, grant);
        end
      end
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || (m1_ready ? m1_rdata : m0_rdata) !== e.d || c !== e.cyc) begin
          fails++;
          $display("FAIL write_done: got m%0d data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                   m1_ready ? 1 : 0, m1_ready ? m1_rdata : m0_rdata, c, e.m, e.d, e.cyc);
        end
        $display("[TB] write_wait: m%0d ready cycle %0d rdata %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m1_req = 1'b0;
    m1_we = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL write_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0020;
    model_rdata[0] = 32'hFFFF_FFFF;
    sb.push_back('{0, model_rdata[0], 6});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        tests++;
        if (s_req !== 1'b1 || timeout_err !== 1'b0) begin
          fails++;
          $display("FAIL timeout_c5: got s_req=%b terr=%b, required 1 0", s_req, timeout_err);
        end
      end
      if (c == 6) begin
        tests++;
        if (s_req !== 1'b0 || timeout_err !== 1'b1) begin
          fails++;
          $display("FAIL timeout_c6: got s_req=%b terr=%b, required 0 1", s_req, timeout_err);
        end
      end
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || (m1_ready ? m1_rdata : m0_rdata) !== e.d || c !== e.cyc) begin
          fails++;
          $display("FAIL timeout_done: got m%0d data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                   m1_ready ? 1 : 0, m1_ready ? m1_rdata : m0_rdata, c, e.m, e.d, e.cyc);
        end
        $display("[TB] timeout: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL timeout_wait: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    // a normal transfer afterwards still completes; the flag stays set
    slave_en = 1'b1;
    slave_wait = 1;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_addr = 32'h0000_0044;
    model_rdata[0] = 32'h44 ^ 32'hA5A5_A5A5;
    sb.push_back('{0, model_rdata[0], 3});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || m0_rdata !== e.d || c !== e.cyc || timeout_err !== 1'b1) begin
          fails++;
          $display("FAIL after_timeout: got m%0d data=%h cycle=%0d terr=%b, required m%0d data=%h cycle=%0d terr=1",
                   m1_ready ? 1 : 0, m0_rdata, c, timeout_err, e.m, e.d, e.cyc);
        end
        $display("[TB] after_timeout: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL after_timeout_wait: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ack_at_timeout();
    exp_t e;
    do_reset();
    slave_en = 1'b1;
    slave_wait = 4;
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0300;
    model_rdata[1] = 32'h300 ^ 32'hA5A5_A5A5;
    sb.push_back('{1, model_rdata[1], 6});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || m1_rdata !== e.d || c !== e.cyc || timeout_err !== 1'b0) begin
          fails++;
          $display("FAIL ack_at_timeout: got m%0d data=%h cycle=%0d terr=%b, required m%0d data=%h cycle=%0d terr=0",
                   m1_ready ? 1 : 0, m1_rdata, c, timeout_err, e.m, e.d, e.cyc);
        end
        $display("[TB] ack_at_timeout: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m1_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL ack_at_timeout_wait: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0500; m0_wdata = 32'h0000_0011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (s_req !== 1'b1 || grant !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_busy: got s_req=%b grant=%b, required 1 01", s_req, grant);
    end
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_req, s_we, s_addr, s_wdata, m0_rdata, m1_rdata, m0_ready, m1_ready, grant, timeout_err} !== 136'd0) begin
      fails++;
      $display("FAIL reset_mid_clear: got s_req=%b s_we=%b s_addr=%h grant=%b m1_rdata=%h, required all zero",
               s_req, s_we, s_addr, grant, m1_rdata);
    end
    rst = 1'b0;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
    $display("[TB] reset_mid: outputs cleared");
    slave_en = 1'b1;
    slave_wait = 0;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0600;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0700;
    model_rdata[0] = 32'h600 ^ 32'hA5A5_A5A5;
    sb.push_back('{0, model_rdata[0], 2});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (grant !== 2'b01) begin
          fails++;
          $display("FAIL reset_tie_grant: got %b, required 01", grant);
        end
      end
      if ((m0_ready || m1_ready) && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ((m1_ready ? 1 : 0) !== e.m || (m1_ready ? m1_rdata : m0_rdata) !== e.d || c !== e.cyc) begin
          fails++;
          $display("FAIL reset_tie_done: got m%0d data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                   m1_ready ? 1 : 0, m1_ready ? m1_rdata : m0_rdata, c, e.m, e.d, e.cyc);
        end
        $display("[TB] reset_tie: m%0d ready cycle %0d data %h", e.m, c, e.d);
      end
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL reset_tie_wait: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
